// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared constants and types for the RV core front end.
//   RV_NOP        canonical NOP (addi x0,x0,0) presented when no instruction is valid
//   OPC_*         major opcodes used by the decoder and redirect resolution
//   fetch_state_e fetch FSM states
//   wrap_inc      modulo-DEPTH pointer increment for non-power-of-two queues
package rv_core_pkg;

  localparam logic [31:0] RV_NOP     = 32'h0000_0013;

  localparam logic [6:0]  OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0]  OPC_ALU_I  = 7'b001_0011;
  localparam logic [6:0]  OPC_JALR   = 7'b110_0111;
  localparam logic [6:0]  OPC_JAL    = 7'b110_1111;
  localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;

  typedef enum logic [1:0] {
    FETCH_BOOT,
    FETCH_RUN,
    FETCH_FLUSH
  } fetch_state_e;

  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of DEPTH x 64-bit {pc, data} entries.
//   clk, rst_n  clock, synchronous active-low reset
//   push        write push_data at the tail
//   push_data   {pc[31:0], data[31:0]}
//   pop         drop the head entry
//   flush       empty the FIFO; wins over push, applied after pop
//   head_data   head entry (undefined when count == 0)
//   count       number of stored entries
module fetch_fifo
  import rv_core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [63:0]   push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [63:0]   head_data,
  output logic [CW-1:0] count
);

  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PW'(wrap_inc(int'(wr_ptr), DEPTH));
      if (pop)  rd_ptr <= PW'(wrap_inc(int'(rd_ptr), DEPTH));
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: holds the PC, issues word reads to instruction memory,
// buffers returned words and presents {inst_data, inst_pc} to the decoder.
//   clk, rst_n      clock, synchronous active-low reset
//   imem_req_*      fetch request (valid/ready, word-aligned addr)
//   imem_rsp_*      in-order read data, one per accepted request
//   inst_*          instruction stream to the decoder (valid/ready, data, pc)
//   redirect_*      new fetch PC from branch/jal/jalr resolution
// Credit rule: outstanding requests + buffered words never exceed DEPTH, so a
// response always finds room in the FIFO.
module instr_fetch_unit
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_state_e  state, state_next;
  logic [31:0]   pc;
  logic [CW-1:0] out_cnt, drop_cnt, fifo_cnt;
  logic [CW-1:0] out_post, drop_post;
  logic [CW:0]   credit_used;
  logic [31:0]   tags [DEPTH];
  logic [PW-1:0] tag_wr, tag_rd;
  logic [63:0]   fifo_head;
  logic          in_run, in_flush, pop, req_fire, rsp_run;
  logic          fifo_push, fifo_flush;

  assign in_run      = (state == FETCH_RUN);
  assign in_flush    = (state == FETCH_FLUSH);
  assign pop         = inst_valid & inst_ready;
  assign credit_used = (CW+1)'(out_cnt) + (CW+1)'(fifo_cnt) - (CW+1)'(pop);
  assign req_fire    = imem_req_valid & imem_req_ready;
  assign rsp_run     = in_run & imem_rsp_valid;
  // Counts after this cycle's accept/response; on redirect these become stale.
  assign out_post    = out_cnt + CW'(req_fire) - CW'(rsp_run);
  assign drop_post   = drop_cnt - CW'(imem_rsp_valid && (drop_cnt != '0));
  // A response arriving with a redirect belongs to the old path.
  assign fifo_push   = rsp_run & ~redirect_valid;
  assign fifo_flush  = in_run & redirect_valid;

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    unique case (state)
      FETCH_BOOT:  state_next = FETCH_RUN;
      FETCH_RUN: begin
        imem_req_valid = (credit_used < (CW+1)'(DEPTH));
        if (redirect_valid && (out_post != '0)) state_next = FETCH_FLUSH;
      end
      FETCH_FLUSH: if (drop_post == '0) state_next = FETCH_RUN;
      default:     state_next = FETCH_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH_BOOT;
      pc       <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
    end else begin
      state <= state_next;
      if (redirect_valid && (state != FETCH_BOOT)) pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (req_fire)                          pc <= pc + 32'd4;
      if (in_run) begin
        if (redirect_valid) begin
          out_cnt  <= '0;
          drop_cnt <= out_post;
          tag_wr   <= '0;
          tag_rd   <= '0;
        end else begin
          out_cnt <= out_post;
          if (req_fire)       tag_wr <= PW'(wrap_inc(int'(tag_wr), DEPTH));
          if (imem_rsp_valid) tag_rd <= PW'(wrap_inc(int'(tag_rd), DEPTH));
        end
      end
      if (in_flush) drop_cnt <= drop_post;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tags[tag_wr] <= pc;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({tags[tag_rd], imem_rsp_data}),
    .pop       (pop),
    .flush     (fifo_flush),
    .head_data (fifo_head),
    .count     (fifo_cnt)
  );

  assign imem_req_addr = pc;
  assign inst_valid    = (fifo_cnt != '0);
  assign inst_data     = inst_valid ? fifo_head[31:0]  : RV_NOP;
  assign inst_pc       = inst_valid ? fifo_head[63:32] : '0;

endmodule
